// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequence player: colours, players,
// playback FSM states, sequence-word layout and the LFSR polynomial.
package simon_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    BLUE   = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    P1 = 2'd0,
    P2 = 2'd1
  } player_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int SEQ_W        = 6;
  localparam int SEQ_COL_LSB  = 0;
  localparam int SEQ_LAMP_BIT = 2;
  localparam int SEQ_STEP_LSB = 3;

  // Taps 16,14,13,11 map to register bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16_module.sv
// Free-running 16-bit Fibonacci LFSR, shifting left every clock.
module lfsr16_module
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_lfsr
);

  // An all-zero seed would lock the register, so it is substituted.
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? DEFAULT_SEED : SEED;

  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= SEED_EFF;
    else          r_lfsr <= lfsr_next(r_lfsr);
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/sequence_player_module.sv
// Builds per-player random colour sequences and replays one of them as
// timed lamp-on / lamp-off sequence words for the LED display stage.
module sequence_player_module
  import simon_pkg::*;
#(
  parameter int          MAX_LEN    = 32,
  parameter int          ON_CYCLES  = 100_000_000,
  parameter int          OFF_CYCLES = 40_000_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_player,
  input  logic       i_append,
  input  logic       i_clear,
  input  logic       i_start,
  output logic [1:0] o_player,
  output logic [5:0] o_seq_p1,
  output logic [5:0] o_seq_p2,
  output logic       o_busy,
  output logic       o_done,
  output logic [5:0] o_count_p1,
  output logic [5:0] o_count_p2
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [5:0]    MAX_CNT  = 6'(MAX_LEN);

  state_e          r_state, w_next_state;
  logic [TW-1:0]   r_timer;
  logic [4:0]      r_step;
  logic [5:0]      r_len;
  logic [1:0]      r_player;
  logic [5:0]      r_count_p1, r_count_p2;
  logic [1:0]      r_mem_p1 [MAX_LEN];
  logic [1:0]      r_mem_p2 [MAX_LEN];

  logic [15:0]     w_lfsr;
  logic            w_unused_lfsr;
  logic            w_idle, w_player_ok, w_start_ok, w_clear_ok, w_append_ok;
  logic [5:0]      w_sel_count;
  logic            w_on_last, w_off_last, w_last_step;
  logic            w_show, w_lamp;
  color_e          w_col;
  logic [SEQ_W-1:0] w_word;

  lfsr16_module #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_lfsr  (w_lfsr)
  );
  assign w_unused_lfsr = ^w_lfsr[15:2];

  assign w_idle      = (r_state == S_IDLE);
  assign w_player_ok = ~i_player[1];
  assign w_sel_count = i_player[0] ? r_count_p2 : r_count_p1;
  assign w_start_ok  = w_idle & i_start & w_player_ok;
  assign w_clear_ok  = w_idle & i_clear;
  // Start and clear both win over an append issued in the same cycle.
  assign w_append_ok = w_idle & i_append & w_player_ok & ~i_clear & ~w_start_ok
                       & (w_sel_count < MAX_CNT);

  assign w_on_last   = (r_timer == ON_LAST);
  assign w_off_last  = (r_timer == OFF_LAST);
  assign w_last_step = ({1'b0, r_step} == (r_len - 6'd1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    w_show       = 1'b0;
    w_lamp       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next_state = (w_sel_count == 6'd0) ? S_DONE : S_ON;
      end
      S_ON: begin
        o_busy = 1'b1;
        w_show = 1'b1;
        w_lamp = 1'b1;
        if (w_on_last) w_next_state = S_OFF;
      end
      S_OFF: begin
        o_busy = 1'b1;
        w_show = 1'b1;
        if (w_off_last) w_next_state = w_last_step ? S_DONE : S_ON;
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer    <= '0;
      r_step     <= '0;
      r_len      <= '0;
      r_player   <= '0;
      r_count_p1 <= '0;
      r_count_p2 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_player <= i_player;
            r_len    <= w_sel_count;
            r_step   <= '0;
            r_timer  <= '0;
          end
        end
        S_ON: r_timer <= w_on_last ? '0 : r_timer + 1'b1;
        S_OFF: begin
          if (w_off_last) begin
            r_timer <= '0;
            if (!w_last_step) r_step <= r_step + 5'd1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase

      if (w_clear_ok) begin
        r_count_p1 <= '0;
        r_count_p2 <= '0;
      end else if (w_append_ok) begin
        if (i_player[0]) r_count_p2 <= r_count_p2 + 6'd1;
        else             r_count_p1 <= r_count_p1 + 6'd1;
      end
    end
  end

  // Colour storage is not reset; only the counts define valid contents.
  always_ff @(posedge i_clk) begin
    if (w_append_ok) begin
      if (i_player[0]) r_mem_p2[r_count_p2[AW-1:0]] <= w_lfsr[1:0];
      else             r_mem_p1[r_count_p1[AW-1:0]] <= w_lfsr[1:0];
    end
  end

  assign w_col  = color_e'((r_player == 2'(P2)) ? r_mem_p2[r_step[AW-1:0]]
                                                : r_mem_p1[r_step[AW-1:0]]);
  assign w_word = {r_step[2:0], w_lamp, w_col};

  assign o_seq_p1   = (w_show && r_player == 2'(P1)) ? w_word : '0;
  assign o_seq_p2   = (w_show && r_player == 2'(P2)) ? w_word : '0;
  assign o_player   = r_player;
  assign o_count_p1 = r_count_p1;
  assign o_count_p2 = r_count_p2;

endmodule

// File: tb/tb_sequence_player_module.sv
// Randomised scoreboard bench for sequence_player_module: a high-level model
// predicts every playback cycle and a monitor checks the DUT against it.
module tb_sequence_player_module;

  localparam int MAX_LEN = 8;
  localparam int ON_C    = 4;
  localparam int OFF_C   = 2;
  localparam int STEP_C  = ON_C + OFF_C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] i_player = '0;
  logic       i_append = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] o_player;
  logic [5:0] o_seq_p1, o_seq_p2;
  logic       o_busy, o_done;
  logic [5:0] o_count_p1, o_count_p2;

  sequence_player_module #(
    .MAX_LEN    (MAX_LEN),
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_player   (i_player),
    .i_append   (i_append),
    .i_clear    (i_clear),
    .i_start    (i_start),
    .o_player   (o_player),
    .o_seq_p1   (o_seq_p1),
    .o_seq_p2   (o_seq_p2),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_count_p1 (o_count_p1),
    .o_count_p2 (o_count_p2)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int edge_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] m_mem [2][MAX_LEN];
  int         m_cnt [2];
  logic       pb_active = 1'b0;
  logic       done_seen = 1'b0;
  int         done_edge = 0;
  int         start_edge = 0;
  int         exp_len = 0;
  // Entry: {player[1:0], busy, done, seq_p1[5:0], seq_p2[5:0]}
  logic [15:0] exp_q[$];

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [15:0] obs, exp;
    if (rst_n) begin
      if (o_busy || o_done) begin
        obs = {o_player, o_busy, o_done, o_seq_p1, o_seq_p2};
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(obs), 32'h0);
        end else begin
          exp = exp_q.pop_front();
          check("playback_word", 32'(obs), 32'(exp));
        end
        if (o_done) begin
          done_seen = 1'b1;
          done_edge = edge_cnt;
        end
      end else begin
        check("idle_words_zero", {20'd0, o_seq_p1, o_seq_p2}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_append(input int p);
    logic [15:0] l;
    @(negedge clk);
    l = lfsr_after(edge_cnt);
    i_player = 2'(p);
    i_append = 1'b1;
    if (!pb_active && p < 2 && m_cnt[p] < MAX_LEN) begin
      m_mem[p][m_cnt[p]] = l[1:0];
      m_cnt[p]++;
    end
    @(negedge clk);
    i_append = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    i_clear = 1'b1;
    if (!pb_active) begin
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic issue_start(input int p);
    logic [4:0] sv;
    logic [5:0] w;
    @(negedge clk);
    i_player = 2'(p);
    i_start  = 1'b1;
    if (!pb_active && p < 2) begin
      exp_len = m_cnt[p];
      for (int s = 0; s < exp_len; s++) begin
        sv = 5'(s);
        for (int c = 0; c < STEP_C; c++) begin
          w = {sv[2:0], (c < ON_C) ? 1'b1 : 1'b0, m_mem[p][s]};
          exp_q.push_back({2'(p), 1'b1, 1'b0, (p == 0) ? w : 6'd0, (p == 1) ? w : 6'd0});
        end
      end
      exp_q.push_back({2'(p), 1'b0, 1'b1, 6'd0, 6'd0});
      start_edge = edge_cnt + 1;
      done_seen  = 1'b0;
      pb_active  = 1'b1;
    end
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < exp_len * STEP_C + 20 && !done_seen; i++) @(posedge clk);
    check("done_seen", 32'(done_seen), 32'd1);
    if (done_seen) check("done_latency", 32'(done_edge - start_edge), 32'(exp_len * STEP_C));
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    pb_active = 1'b0;
  endtask

  task automatic play(input int p);
    issue_start(p);
    if (p < 2) begin
      wait_done();
    end else begin
      repeat (3) begin
        @(negedge clk);
        check("invalid_start_idle", {30'd0, o_busy, o_done}, 32'd0);
      end
    end
  endtask

  task automatic check_counts(input string name);
    check({name, "_p1"}, 32'(o_count_p1), 32'(m_cnt[0]));
    check({name, "_p2"}, 32'(o_count_p2), 32'(m_cnt[1]));
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] l;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    #1;
    check("reset_outputs", {o_player, o_seq_p1, o_seq_p2, o_busy, o_done, o_count_p1, o_count_p2},
          32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: three P1 appends
    for (int i = 0; i < 3; i++) begin do_append(0); gap(); end
    check_counts("count_after_3");

    // 2: replay P1 (three steps)
    play(0);

    // 3: P2 saturation and full replay with step-index wrap
    for (int i = 0; i < 10; i++) begin do_append(1); gap(); end
    check_counts("count_saturate");
    play(1);

    // 4: invalid players, random mix, then an empty replay
    play(2);
    play(3);
    for (int r = 0; r < 4; r++) begin
      do_clear();
      repeat ($urandom_range(1, 6)) begin do_append(int'($urandom_range(0, 3))); gap(); end
      check_counts("count_random");
      play(int'($urandom_range(0, 2)));
    end
    do_clear();
    check_counts("count_cleared");
    play(0);

    // 5: commands issued mid-playback are ignored
    for (int i = 0; i < 3; i++) do_append(0);
    issue_start(0);
    repeat (2) @(negedge clk);
    do_append(0);
    do_clear();
    issue_start(1);
    wait_done();
    check_counts("count_after_busy_cmds");

    // 6: asynchronous reset in the middle of step 2
    issue_start(0);
    for (int i = 0; i < 40 && edge_cnt < start_edge + 13; i++) @(negedge clk);
    check("busy_before_reset", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_play", {o_player, o_seq_p1, o_seq_p2, o_busy, o_done, o_count_p1, o_count_p2},
          32'd0);
    exp_q.delete();
    pb_active = 1'b0;
    done_seen = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    @(negedge clk);
    rst_n    = 1'b1;
    l        = lfsr_after(0);
    i_player = 2'd0;
    i_append = 1'b1;
    m_mem[0][0] = l[1:0];
    m_cnt[0] = 1;
    @(negedge clk);
    i_append = 1'b0;
    check_counts("count_after_reset");
    play(0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_player_module.md
Name: sequence_player_module

Overview:
- Upstream feeder of the LED display stage in the Simon (Genius) game.
- Builds a random colour sequence per player from an internal LFSR.
- On request, replays a player's sequence one colour at a time with timed lamp-on/lamp-off phases.
- Drives the two 6-bit per-player sequence words and the player selector that the LED display consumes.

Parameters:
- MAX_LEN, 32, maximum stored colours per player. Power of two, at most 32.
- ON_CYCLES, 100_000_000, clock cycles a colour lamp stays lit (0.5 s at 200 MHz). Must be at least 1.
- OFF_CYCLES, 40_000_000, dark gap after each colour. Must be at least 1.
- LFSR_SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- i_clk  in  1  system clock, 200 MHz
- i_rst_n  in  1  asynchronous active-low reset
- i_player  in  2  player select for i_append and i_start: 0 = P1, 1 = P2, 2 and 3 invalid
- i_append  in  1  one-cycle pulse: append one random colour to the selected player's sequence
- i_clear  in  1  one-cycle pulse: zero both players' counts
- i_start  in  1  one-cycle pulse: replay the selected player's sequence
- o_player  out  2  latched player of the current or last playback
- o_seq_p1  out  6  P1 sequence word
- o_seq_p2  out  6  P2 sequence word
- o_busy  out  1  high while playback is in progress
- o_done  out  1  one-cycle pulse at the end of a playback
- o_count_p1  out  6  stored length for P1, range 0..MAX_LEN
- o_count_p2  out  6  stored length for P2, range 0..MAX_LEN

Behaviour:
- Reset: all outputs, counts, the step index and the timer are 0; the FSM is in IDLE; the LFSR loads LFSR_SEED. All of this is asynchronous, including reset asserted mid-playback.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. Shifts left every cycle regardless of state. New colour = lfsr[1:0] in the cycle i_append is sampled.
- Colour code: 0 = green, 1 = yellow, 2 = red, 3 = blue.
- Sequence word layout:
  - [1:0] colour
  - [2] lamp on
  - [5:3] step index mod 8
  - The non-selected player's word is all zeros.
- Storage: two MAX_LEN x 2-bit arrays. Writes are synchronous.
- i_append:
  - Valid player, state IDLE, count < MAX_LEN: write colour at index count, then count increments.
  - Otherwise the pulse is ignored. A full count is never exceeded.
- i_clear: accepted only in IDLE; zeros both counts, contents stay don't-care. Takes priority over an i_append in the same cycle.
- FSM states: IDLE, ON, OFF, DONE.
- IDLE:
  - i_start with a valid player: latch o_player and len = that player's count, step = 0, timer = 0.
  - If len = 0, go to DONE; otherwise go to ON.
  - Invalid player: i_start is ignored.
  - i_start has priority over an i_append in the same cycle; that append is dropped.
- ON:
  - Selected word = {step[2:0], 1, mem[step]}.
  - After ON_CYCLES cycles: timer = 0, go to OFF.
- OFF:
  - Selected word = {step[2:0], 0, mem[step]}.
  - After OFF_CYCLES cycles: if step = len-1, go to DONE; else step increments and the FSM goes to ON.
- DONE: o_done = 1 for exactly one cycle; the selected word is zeroed; return to IDLE.
- Latency:
  - i_start sampled at edge k: lamp on from k+1.
  - Each step lasts ON_CYCLES + OFF_CYCLES.
  - o_done is high in cycle k + 1 + len*(ON_CYCLES+OFF_CYCLES).
- o_busy = 1 in ON and OFF only.
- i_start, i_append and i_clear arriving during ON, OFF or DONE are ignored.
- o_player holds its value after playback completes.
- Timer width is $clog2(max(ON_CYCLES, OFF_CYCLES)). The timer compares against N-1 and never wraps past it.

Decomposition:
- Package simon_pkg:
  - colour enum color_e (GREEN, YELLOW, RED, BLUE)
  - player enum (P1 = 0, P2 = 1)
  - FSM state enum
  - sequence-word field positions
  - LFSR tap constant and default seed
- One sub-module, lfsr16_module: free-running 16-bit LFSR with a seed parameter and output o_lfsr[15:0].

Test Plan:
All scenarios use ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=8 unless stated.
1. Reset, then three i_append pulses for P1 -> o_count_p1=3, o_count_p2=0; stored colours equal a reference-model LFSR sampled at each append cycle.
2. Start P1 with count 3 at edge k:
   - o_busy high for 18 cycles; o_done pulses at k+19.
   - o_seq_p1[2] pattern is 4 on, 2 off, repeated 3 times; o_seq_p1[5:3] reads 0, 1, 2.
   - o_seq_p2 stays 0.
3. Ten appends to P2 -> o_count_p2 saturates at 8. Start P2 -> 8 steps; the index field wraps 7 -> 0 only at the end; o_done pulses.
4. Start with i_player=2 -> no busy, no done. Start P1 with count 0 -> o_done pulses at k+1, lamp never lit.
5. i_append and i_clear pulsed during playback -> counts unchanged. i_start during ON -> step timing unaffected.
6. Assert i_rst_n low in the middle of step 2 -> outputs zero in the same cycle, counts 0, FSM in IDLE. After release, a P1 append stores lfsr[1:0] from the seed again.
